lut_rd_sched: RTL and testbench

- Scheduler/arbiter sharing the single read port of the GELU LUT SRAM (8k x 32b) between the parallel GELU lanes.
- Accepts per-lane lookup requests (12-bit address plus sign) and grants one per cycle, round-robin.
- Issues the SRAM read, selects the upper or lower 16-bit half by the stored sign, and returns a per-lane response pulse.
- Replaces the fixed 5-state LUT sequencing in the accelerator top. Reads are stalled while the host is rewriting the LUT.

---
 rtl/lut_sched_pkg.sv | 20 ++
 rtl/lut_rd_sched_if.sv | 25 ++
 rtl/lut_rr_arb.sv | 48 ++++
 rtl/lut_rd_sched.sv | 90 +++++++++
 tb/tb_lut_rd_sched.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lut_sched_pkg.sv
// Shared constants, pipeline stage type and half-word select for the GELU LUT read scheduler.
package lut_sched_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_LUT_AW  = 12;
  localparam int DEF_SRAM_AW = 13;
  localparam int DEF_DW      = 16;

  // Stage payload is sized from the package defaults, so the top must be built with matching N_REQ/DW.
  typedef struct packed {
    logic                 valid;
    logic [DEF_N_REQ-1:0] tag;
    logic [DEF_N_REQ-1:0] sign;
  } lut_stage_t;

  function automatic logic [DEF_DW-1:0] sel_half(input logic [2*DEF_DW-1:0] word, input logic sign);
    return sign ? word[2*DEF_DW-1:DEF_DW] : word[DEF_DW-1:0];
  endfunction

endpackage

// File: rtl/lut_rd_sched_if.sv
// Lane-side request/response bundle of the LUT read scheduler; master = GELU lanes, slave = scheduler.
interface lut_rd_sched_if #(
  parameter int N_REQ  = lut_sched_pkg::DEF_N_REQ,
  parameter int LUT_AW = lut_sched_pkg::DEF_LUT_AW,
  parameter int DW     = lut_sched_pkg::DEF_DW
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*LUT_AW-1:0] req_addr;
  logic [N_REQ-1:0]        req_sign;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ*DW-1:0]     rsp_data;

  modport master (
    output req_valid, req_addr, req_sign,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_sign,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/lut_rr_arb.sv
// Round-robin arbiter: one-hot grant searched upward from ptr, ptr moves past the winner.
module lut_rr_arb #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  int            sum;

  always_comb begin
    // NOTE: every output gets a default before the search so no path can infer a latch.
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    sum         = 0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        sum = int'(ptr) + i;
        if (sum >= N) sum = sum - N;
        idx = IW'(sum);
        if (!grant_valid && req[idx]) begin
          grant_valid = 1'b1;
          grant_idx   = idx;
        end
      end
    end
    grant = grant_valid ? (N'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all registers sample pre-edge values.
    if (rst) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/lut_rd_sched.sv
// Shares the GELU LUT SRAM read port between lanes: RR grant, 2-cycle read pipeline, per-lane half select.
// Optional macro LUT_ADDR_MERGE_EN also grants every valid lane sharing the winner's address.
module lut_rd_sched
  import lut_sched_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int LUT_AW  = DEF_LUT_AW,
  parameter int SRAM_AW = DEF_SRAM_AW,
  parameter int DW      = DEF_DW,
  localparam int IW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  lut_rd_sched_if.slave      lanes,
  input  logic               lut_lock,
  output logic               sram_rd_en,
  output logic [SRAM_AW-1:0] sram_raddr,
  input  logic [2*DW-1:0]    sram_rdata,
  output logic               busy
);

  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  ready;
  logic [IW-1:0]     grant_idx;
  logic              grant_valid;
  logic              arb_en;
  logic [LUT_AW-1:0] addr_v [N_REQ];
  logic [LUT_AW-1:0] prim_addr;

  lut_stage_t        s1;
  logic              s2_valid;
  logic [N_REQ-1:0]  s2_tag;
  logic [DW-1:0]     rsp_q [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign addr_v[i] = lanes.req_addr[i*LUT_AW +: LUT_AW];
    assign lanes.rsp_data[i*DW +: DW] = rsp_q[i];
  end

  // Lock and reset both block new grants in the same cycle; issued reads are unaffected by lock.
  assign arb_en = !lut_lock && !rst;

  lut_rr_arb #(.N(N_REQ)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .en          (arb_en),
    .req         (lanes.req_valid),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign prim_addr = addr_v[grant_idx];

  always_comb begin
    ready = grant;
`ifdef LUT_ADDR_MERGE_EN
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_valid && lanes.req_valid[i] && (addr_v[i] == prim_addr)) ready[i] = 1'b1;
    end
`endif
  end

  assign lanes.req_ready = ready;
  assign sram_rd_en      = grant_valid;
  assign sram_raddr      = SRAM_AW'(prim_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s2_valid <= 1'b0;
      s2_tag   <= '0;
      // NOTE: the result array is small register storage and is reset so rsp_data reads 0 after reset.
      rsp_q    <= '{default: '0};
    end else begin
      s1.valid <= grant_valid;
      s1.tag   <= ready;
      s1.sign  <= lanes.req_sign;
      s2_valid <= s1.valid;
      s2_tag   <= s1.tag;
      for (int i = 0; i < N_REQ; i++) begin
        if (s1.valid && s1.tag[i]) rsp_q[i] <= sel_half(sram_rdata, s1.sign[i]);
      end
    end
  end

  assign lanes.rsp_valid = s2_valid ? s2_tag : '0;
  assign busy            = (|lanes.req_valid) | s1.valid | s2_valid;

endmodule

// File: tb/tb_lut_rd_sched.sv
// Self-checking bench for lut_rd_sched: directed scenarios plus a randomized run against a schedule-based model.
module tb_lut_rd_sched;
  import lut_sched_pkg::*;

  localparam int N    = 4;
  localparam int AW   = 12;
  localparam int SAW  = 13;
  localparam int DW   = 16;
  localparam int NCYC = 400;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           lut_lock = 1'b0;
  logic           sram_rd_en;
  logic [SAW-1:0] sram_raddr;
  logic [31:0]    sram_rdata;
  logic           busy;
  logic [31:0]    mem [0:8191];

  int n_checks = 0;
  int n_fail   = 0;

  lut_rd_sched_if #(.N_REQ(N), .LUT_AW(AW), .DW(DW)) lanes ();

  lut_rd_sched #(.N_REQ(N), .LUT_AW(AW), .SRAM_AW(SAW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .lanes      (lanes.slave),
    .lut_lock   (lut_lock),
    .sram_rd_en (sram_rd_en),
    .sram_raddr (sram_raddr),
    .sram_rdata (sram_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (sram_rd_en) sram_rdata <= mem[sram_raddr];

  task automatic set_lane(input int l, input logic [11:0] a, input logic s);
    lanes.req_addr[l*AW +: AW] = a;
    lanes.req_sign[l]          = s;
  endtask

  function automatic logic [15:0] rsp_lane(input int l);
    return lanes.rsp_data[l*DW +: DW];
  endfunction

  task automatic idle_inputs();
    lanes.req_valid = '0;
    lanes.req_addr  = '0;
    lanes.req_sign  = '0;
    lut_lock        = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lanes.req_valid = 4'hF;
    #1;
    n_checks++; if (lanes.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", lanes.req_ready); end
    n_checks++; if (sram_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", sram_rd_en); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (lanes.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0000", lanes.rsp_valid); end
    n_checks++; if (lanes.rsp_data !== 64'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h expected 0", lanes.rsp_data); end
  endtask

  task automatic test_single(input logic s, input logic [15:0] exp_data);
    do_reset();
    lanes.req_valid = 4'b0100;
    set_lane(2, 12'h0A5, s);
    #1;
    n_checks++; if (lanes.req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b expected 0100", lanes.req_ready); end
    n_checks++; if (sram_rd_en !== 1'b1) begin n_fail++; $display("FAIL single_rd_en: got %b expected 1", sram_rd_en); end
    n_checks++; if (sram_raddr !== 13'h00A5) begin n_fail++; $display("FAIL single_raddr: got %h expected 00a5", sram_raddr); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_c0: got %b expected 1", busy); end
    @(negedge clk);
    lanes.req_valid = '0;
    #1;
    n_checks++; if (lanes.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_early_rsp: got %b expected 0000", lanes.rsp_valid); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_c1: got %b expected 1", busy); end
    @(negedge clk);
    #1;
    n_checks++; if (lanes.rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL single_rsp_valid: got %b expected 0100", lanes.rsp_valid); end
    n_checks++; if (rsp_lane(2) !== exp_data) begin n_fail++; $display("FAIL single_rsp_data: got %h expected %h", rsp_lane(2), exp_data); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_c2: got %b expected 1", busy); end
    @(negedge clk);
    #1;
    n_checks++; if (lanes.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_rsp_pulse: got %b expected 0000", lanes.rsp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_c3: got %b expected 0", busy); end
    n_checks++; if (rsp_lane(2) !== exp_data) begin n_fail++; $display("FAIL single_rsp_hold: got %h expected %h", rsp_lane(2), exp_data); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  signs = 4'b1010;
    logic [31:0] w;
    logic [15:0] exp_d;
    int          lane;
    do_reset();
    lanes.req_valid = 4'hF;
    for (int l = 0; l < N; l++) set_lane(l, 12'(12'h200 + l), signs[l]);
    for (int k = 0; k < 10; k++) begin
      if (k == 8) lanes.req_valid = '0;
      #1;
      if (k < 8) begin
        n_checks++; if (lanes.req_ready !== 4'(1 << (k % 4))) begin n_fail++; $display("FAIL rr_grant c%0d: got %b expected %b", k, lanes.req_ready, 4'(1 << (k % 4))); end
      end
      if (k >= 2) begin
        lane  = (k - 2) % 4;
        w     = mem[12'(12'h200 + lane)];
        exp_d = signs[lane] ? w[31:16] : w[15:0];
        n_checks++; if (lanes.rsp_valid !== 4'(1 << lane)) begin n_fail++; $display("FAIL rr_rsp_valid c%0d: got %b expected %b", k, lanes.rsp_valid, 4'(1 << lane)); end
        n_checks++; if (rsp_lane(lane) !== exp_d) begin n_fail++; $display("FAIL rr_rsp_data c%0d: got %h expected %h", k, rsp_lane(lane), exp_d); end
      end else begin
        n_checks++; if (lanes.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rr_rsp_early c%0d: got %b expected 0000", k, lanes.rsp_valid); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lock();
    logic [31:0] w0 = mem[12'h300];
    logic [31:0] w1 = mem[12'h301];
    do_reset();
    lanes.req_valid = 4'b0011;
    set_lane(0, 12'h300, 1'b0);
    set_lane(1, 12'h301, 1'b0);
    #1;
    n_checks++; if (lanes.req_ready !== 4'b0001) begin n_fail++; $display("FAIL lock_c0_ready: got %b expected 0001", lanes.req_ready); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      lanes.req_valid = 4'b0010;
      lut_lock = 1'b1;
      #1;
      n_checks++; if (lanes.req_ready !== 4'b0000) begin n_fail++; $display("FAIL lock_ready c%0d: got %b expected 0000", k, lanes.req_ready); end
      n_checks++; if (sram_rd_en !== 1'b0) begin n_fail++; $display("FAIL lock_rd_en c%0d: got %b expected 0", k, sram_rd_en); end
      if (k == 2) begin
        n_checks++; if (lanes.rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL lock_inflight_rsp: got %b expected 0001", lanes.rsp_valid); end
        n_checks++; if (rsp_lane(0) !== w0[15:0]) begin n_fail++; $display("FAIL lock_inflight_data: got %h expected %h", rsp_lane(0), w0[15:0]); end
      end
    end
    @(negedge clk);
    lut_lock = 1'b0;
    #1;
    n_checks++; if (lanes.req_ready !== 4'b0010) begin n_fail++; $display("FAIL lock_release_ready: got %b expected 0010", lanes.req_ready); end
    n_checks++; if (sram_raddr !== 13'h0301) begin n_fail++; $display("FAIL lock_release_raddr: got %h expected 0301", sram_raddr); end
    @(negedge clk);
    lanes.req_valid = '0;
    @(negedge clk);
    #1;
    n_checks++; if (lanes.rsp_valid !== 4'b0010 || rsp_lane(1) !== w1[15:0]) begin n_fail++; $display("FAIL lock_lane1_rsp: got %b/%h expected 0010/%h", lanes.rsp_valid, rsp_lane(1), w1[15:0]); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    lanes.req_valid = 4'b1000;
    set_lane(3, 12'h0A5, 1'b1);
    #1;
    n_checks++; if (lanes.req_ready !== 4'b1000) begin n_fail++; $display("FAIL mid_grant: got %b expected 1000", lanes.req_ready); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (lanes.req_ready !== 4'b0000 || sram_rd_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b/%b expected 0000/0", lanes.req_ready, sram_rd_en); end
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      rst = 1'b0;
      lanes.req_valid = '0;
      #1;
      n_checks++; if (lanes.rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL mid_rsp c%0d: got %b expected 0000", k, lanes.rsp_valid); end
      n_checks++; if (lanes.rsp_data !== 64'h0) begin n_fail++; $display("FAIL mid_data c%0d: got %h expected 0", k, lanes.rsp_data); end
    end
    @(negedge clk);
    lanes.req_valid = 4'hF;
    #1;
    n_checks++; if (lanes.req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr_reset: got %b expected 0001", lanes.req_ready); end
    @(negedge clk);
    lanes.req_valid = '0;
  endtask

  task automatic test_merge();
    do_reset();
    lanes.req_valid = 4'b0011;
    set_lane(0, 12'h010, 1'b0);
    set_lane(1, 12'h010, 1'b1);
    #1;
`ifdef LUT_ADDR_MERGE_EN
    n_checks++; if (lanes.req_ready !== 4'b0011) begin n_fail++; $display("FAIL merge_ready: got %b expected 0011", lanes.req_ready); end
    @(negedge clk);
    lanes.req_valid = '0;
    #1;
    n_checks++; if (sram_rd_en !== 1'b0) begin n_fail++; $display("FAIL merge_single_read: got %b expected 0", sram_rd_en); end
    @(negedge clk);
    #1;
    n_checks++; if (lanes.rsp_valid !== 4'b0011) begin n_fail++; $display("FAIL merge_rsp_valid: got %b expected 0011", lanes.rsp_valid); end
    n_checks++; if (rsp_lane(0) !== 16'h5555 || rsp_lane(1) !== 16'hAAAA) begin n_fail++; $display("FAIL merge_data: got %h/%h expected 5555/aaaa", rsp_lane(0), rsp_lane(1)); end
`else
    n_checks++; if (lanes.req_ready !== 4'b0001) begin n_fail++; $display("FAIL nomerge_ready0: got %b expected 0001", lanes.req_ready); end
    @(negedge clk);
    lanes.req_valid = 4'b0010;
    #1;
    n_checks++; if (lanes.req_ready !== 4'b0010 || sram_rd_en !== 1'b1) begin n_fail++; $display("FAIL nomerge_ready1: got %b/%b expected 0010/1", lanes.req_ready, sram_rd_en); end
    @(negedge clk);
    lanes.req_valid = '0;
    #1;
    n_checks++; if (lanes.rsp_valid !== 4'b0001 || rsp_lane(0) !== 16'h5555) begin n_fail++; $display("FAIL nomerge_rsp0: got %b/%h expected 0001/5555", lanes.rsp_valid, rsp_lane(0)); end
    @(negedge clk);
    #1;
    n_checks++; if (lanes.rsp_valid !== 4'b0010 || rsp_lane(1) !== 16'hAAAA) begin n_fail++; $display("FAIL nomerge_rsp1: got %b/%h expected 0010/aaaa", lanes.rsp_valid, rsp_lane(1)); end
`endif
    @(negedge clk);
  endtask

  task automatic test_busy();
    do_reset();
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle: got %b expected 0", busy); end
    @(negedge clk);
    lanes.req_valid = 4'b0010;
    set_lane(1, 12'h000, 1'b0);
    for (int k = 0; k <= 3; k++) begin
      #1;
      n_checks++; if (busy !== (k < 3)) begin n_fail++; $display("FAIL busy c%0d: got %b expected %b", k, busy, (k < 3)); end
      @(negedge clk);
      lanes.req_valid = '0;
    end
  endtask

  task automatic test_random();
    logic [3:0]  sched_mask [0:NCYC+2];
    logic [15:0] sched_data [0:NCYC+2][0:3];
    logic [15:0] model_data [0:3];
    logic [11:0] a [0:3];
    logic [31:0] w;
    logic [3:0]  v, s, exp_ready;
    logic        r, lk, exp_busy;
    int          ptr, g, l;
    do_reset();
    for (int c = 0; c <= NCYC + 2; c++) sched_mask[c] = '0;
    for (int i = 0; i < N; i++) model_data[i] = '0;
    ptr = 0;
    for (int c = 0; c < NCYC; c++) begin
      r  = ($urandom_range(0, 39) == 0);
      lk = ($urandom_range(0, 7) == 0);
      v  = 4'($urandom);
      s  = 4'($urandom);
      for (int i = 0; i < N; i++) a[i] = ($urandom_range(0, 1) == 1) ? 12'(12'h100 + $urandom_range(0, 2)) : 12'($urandom);
      rst = r;
      lut_lock = lk;
      lanes.req_valid = v;
      for (int i = 0; i < N; i++) set_lane(i, a[i], s[i]);
      #1;
      for (int i = 0; i < N; i++) if (sched_mask[c][i]) model_data[i] = sched_data[c][i];
      g = -1;
      exp_ready = '0;
      if (!r && !lk) begin
        for (int i = 0; i < N; i++) begin
          l = (ptr + i) % N;
          if (g < 0 && v[l]) g = l;
        end
      end
      if (g >= 0) begin
        exp_ready[g] = 1'b1;
`ifdef LUT_ADDR_MERGE_EN
        for (int i = 0; i < N; i++) if (v[i] && a[i] == a[g]) exp_ready[i] = 1'b1;
`endif
      end
      exp_busy = (|v) || (sched_mask[c] != 0) || (sched_mask[c+1] != 0);
      n_checks++; if (lanes.req_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready c%0d: got %b expected %b", c, lanes.req_ready, exp_ready); end
      n_checks++; if (sram_rd_en !== (g >= 0)) begin n_fail++; $display("FAIL rand_rd_en c%0d: got %b expected %b", c, sram_rd_en, (g >= 0)); end
      if (g >= 0) begin
        n_checks++; if (sram_raddr !== {1'b0, a[g]}) begin n_fail++; $display("FAIL rand_raddr c%0d: got %h expected %h", c, sram_raddr, {1'b0, a[g]}); end
      end
      n_checks++; if (lanes.rsp_valid !== sched_mask[c]) begin n_fail++; $display("FAIL rand_rsp_valid c%0d: got %b expected %b", c, lanes.rsp_valid, sched_mask[c]); end
      for (int i = 0; i < N; i++) begin
        n_checks++; if (rsp_lane(i) !== model_data[i]) begin n_fail++; $display("FAIL rand_rsp_data c%0d lane%0d: got %h expected %h", c, i, rsp_lane(i), model_data[i]); end
      end
      n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL rand_busy c%0d: got %b expected %b", c, busy, exp_busy); end
      if (r) begin
        sched_mask[c+1] = '0;
        for (int i = 0; i < N; i++) model_data[i] = '0;
        ptr = 0;
      end else if (g >= 0) begin
        w = mem[a[g]];
        sched_mask[c+2] = exp_ready;
        for (int i = 0; i < N; i++) sched_data[c+2][i] = s[i] ? w[31:16] : w[15:0];
        ptr = (g + 1) % N;
      end
      @(negedge clk);
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = $urandom;
    mem[12'h0A5] = 32'hBEEF_1234;
    mem[12'h010] = 32'hAAAA_5555;
    idle_inputs();
    test_reset();
    test_single(1'b1, 16'hBEEF);
    test_single(1'b0, 16'h1234);
    test_round_robin();
    test_lock();
    test_reset_midflight();
    test_merge();
    test_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
